iobus_reg_bank: RTL and testbench

//  Parametrised MicroBlaze MCS IO-bus register bank, successor to the single-register IO-bus block.

---
 rtl/iobus_reg_bank.sv | 241 ++++++++++++++++++++++++
 tb/tb_iobus_reg_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_reg_bank.sv
// -----------------------------------------------------------------------------
// iobus_reg_bank
//   MicroBlaze MCS IO-bus register bank. Provides NUM_OUT byte-writable output
//   registers, NUM_IN byte-capture input registers, a sticky new-data STATUS
//   register (write-1-to-clear), an IRQ_EN mask and a registered level irq.
//   Transfers are acknowledged 1+WAIT_STATES cycles after the strobe.
//
//   Word map (word index relative to BASE_ADDR, N = NUM_OUT+NUM_IN):
//     0 .. NUM_OUT-1   OUT[w]            RW
//     NUM_OUT .. N-1   IN[w-NUM_OUT]     RO
//     N                STATUS            W1C
//     N+1              IRQ_EN            RW
//
//   Parameters: BASE_ADDR (4-byte aligned), NUM_OUT 1..8, NUM_IN 1..8,
//               WAIT_STATES 0..7.
//
// Ports
//   Clk, Reset              system clock, asynchronous active-high reset
//   IO_Addr_Strobe          address valid, 1-cycle pulse
//   IO_Read_Strobe          read request, coincident with IO_Addr_Strobe
//   IO_Write_Strobe         write request, coincident with IO_Addr_Strobe
//   IO_Address              byte address ([1:0] ignored)
//   IO_Byte_Enable          write byte lanes, bit0 = [7:0]
//   IO_Write_Data           write data
//   IO_Read_Data            read data, valid while IO_Ready=1, held otherwise
//   IO_Ready                1-cycle transfer acknowledge
//   data_out                output registers, reg k at [32k+31:32k]
//   data_out_we             per-lane 1-cycle write pulse, aligned with IO_Ready
//   data_in                 input data, reg i at [32i+31:32i]
//   data_in_en              per-lane capture enable
//   irq                     registered |(STATUS & IRQ_EN)
// -----------------------------------------------------------------------------
// state   | meaning
// ST_IDLE | waiting for a strobe that hits the map
// ST_WAIT | wait-state down-counter running
// ST_ACK  | IO_Ready high; write/read committed on entry
// -----------------------------------------------------------------------------
module iobus_reg_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
  parameter int          NUM_OUT     = 2,
  parameter int          NUM_IN      = 2,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IO_Addr_Strobe,
  input  logic                  IO_Read_Strobe,
  input  logic                  IO_Write_Strobe,
  input  logic [31:0]           IO_Address,
  input  logic [3:0]            IO_Byte_Enable,
  input  logic [31:0]           IO_Write_Data,
  output logic [31:0]           IO_Read_Data,
  output logic                  IO_Ready,
  output logic [32*NUM_OUT-1:0] data_out,
  output logic [4*NUM_OUT-1:0]  data_out_we,
  input  logic [32*NUM_IN-1:0]  data_in,
  input  logic [4*NUM_IN-1:0]   data_in_en,
  output logic                  irq
);

  localparam int          NUM_REGS  = NUM_OUT + NUM_IN;
  localparam int          NUM_WORDS = NUM_REGS + 2;
  localparam logic [31:0] MAP_BYTES = 32'(4 * NUM_WORDS);
  localparam logic [4:0]  W_STATUS  = 5'(NUM_REGS);
  localparam logic [4:0]  W_IRQ_EN  = 5'(NUM_REGS + 1);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] offset;
  logic        hit;
  logic        start;
  logic        commit;
  logic [4:0]  live_word;

  logic [4:0]  lat_word;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;
  logic        lat_wr;

  logic [4:0]  cur_word;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  logic        cur_wr;

  logic [2:0]  wait_cnt_q;

  logic [NUM_OUT-1:0][31:0] out_q;
  logic [NUM_OUT-1:0][3:0]  we_q;
  logic [NUM_IN-1:0][31:0]  in_q;
  logic [NUM_IN-1:0]        status_q;
  logic [NUM_IN-1:0]        irq_en_q;
  logic [NUM_IN-1:0]        cap_any;
  logic [NUM_IN-1:0]        status_clr;
  logic [31:0]              rd_mux;

  // Address decode. The subtraction wraps for addresses below BASE_ADDR, so
  // the explicit lower-bound compare keeps them out of the map.
  assign offset    = IO_Address - BASE_ADDR;
  assign hit       = IO_Addr_Strobe && (IO_Address >= BASE_ADDR) && (offset < MAP_BYTES);
  assign live_word = offset[6:2];
  assign start     = (state_q == ST_IDLE) && hit && (IO_Read_Strobe || IO_Write_Strobe);

  // With zero wait states the commit happens on the strobe edge itself, before
  // the latches are loaded, so the live bus is used while still in IDLE.
  assign cur_word  = (state_q == ST_IDLE) ? live_word       : lat_word;
  assign cur_be    = (state_q == ST_IDLE) ? IO_Byte_Enable  : lat_be;
  assign cur_wdata = (state_q == ST_IDLE) ? IO_Write_Data   : lat_wdata;
  assign cur_wr    = (state_q == ST_IDLE) ? IO_Write_Strobe : lat_wr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (WAIT_STATES == 0) state_d = ST_ACK;
          else                  state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit on the edge that enters ACK so data_out, data_out_we and
  // IO_Read_Data all become visible in the same cycle as IO_Ready.
  assign commit   = (state_d == ST_ACK) && (state_q != ST_ACK);
  assign IO_Ready = (state_q == ST_ACK);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
      lat_word   <= 5'd0;
      lat_be     <= 4'd0;
      lat_wdata  <= 32'd0;
      lat_wr     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        lat_word   <= live_word;
        lat_be     <= IO_Byte_Enable;
        lat_wdata  <= IO_Write_Data;
        lat_wr     <= IO_Write_Strobe;
        wait_cnt_q <= WAIT_LOAD;
      end else if ((state_q == ST_WAIT) && (wait_cnt_q != 3'd0)) begin
        wait_cnt_q <= wait_cnt_q - 3'd1;
      end
    end
  end

  // Output registers and their per-lane write pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q <= '0;
      we_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (commit && cur_wr && (cur_word == 5'(k)) && cur_be[b]) begin
            out_q[k][8*b +: 8] <= cur_wdata[8*b +: 8];
            we_q[k][b]         <= 1'b1;
          end else begin
            we_q[k][b]         <= 1'b0;
          end
        end
      end
    end
  end

  assign data_out    = out_q;
  assign data_out_we = we_q;

  always_comb begin
    cap_any = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cap_any[i] = |data_in_en[4*i +: 4];
    end
  end

  // Byte enables do not apply to STATUS clears.
  always_comb begin
    status_clr = '0;
    if (commit && cur_wr && (cur_word == W_STATUS)) begin
      status_clr = cur_wdata[NUM_IN-1:0];
    end
  end

  // Input capture runs in every FSM state; a capture beats a same-cycle clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_q     <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (data_in_en[4*i + b]) begin
            in_q[i][8*b +: 8] <= data_in[32*i + 8*b +: 8];
          end
        end
      end
      status_q <= (status_q & ~status_clr) | cap_any;
      if (commit && cur_wr && (cur_word == W_IRQ_EN)) begin
        irq_en_q <= cur_wdata[NUM_IN-1:0];
      end
      irq <= |(status_q & irq_en_q);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cur_word == 5'(k)) rd_mux = out_q[k];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (cur_word == 5'(NUM_OUT + i)) rd_mux = in_q[i];
    end
    if (cur_word == W_STATUS) rd_mux[NUM_IN-1:0] = status_q;
    if (cur_word == W_IRQ_EN) rd_mux[NUM_IN-1:0] = irq_en_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IO_Read_Data <= 32'd0;
    end else if (commit && !cur_wr) begin
      IO_Read_Data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_iobus_reg_bank.sv
module tb_iobus_reg_bank;

  logic        Clk;
  logic        Reset;
  logic        strb, rds, wrs;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [63:0] din;
  logic [7:0]  din_en;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, irq0, irq1;
  logic [63:0] dout0, dout1;
  logic [7:0]  dwe0, dwe1;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat0, lat1, nrdy0, nrdy1, wec0, wec1;
  logic [31:0] rd0, rd1;
  logic [7:0]  we0, we1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] exp_rd;
    logic [63:0] exp_out;
    logic [7:0]  exp_we;
    logic        exp_irq;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  iobus_reg_bank #(.WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset(Reset),
    .IO_Addr_Strobe(strb), .IO_Read_Strobe(rds), .IO_Write_Strobe(wrs),
    .IO_Address(addr), .IO_Byte_Enable(be), .IO_Write_Data(wdata),
    .IO_Read_Data(rdata0), .IO_Ready(ready0),
    .data_out(dout0), .data_out_we(dwe0),
    .data_in(din), .data_in_en(din_en),
    .irq(irq0)
  );

  iobus_reg_bank #(.WAIT_STATES(3)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .IO_Addr_Strobe(strb), .IO_Read_Strobe(rds), .IO_Write_Strobe(wrs),
    .IO_Address(addr), .IO_Byte_Enable(be), .IO_Write_Data(wdata),
    .IO_Read_Data(rdata1), .IO_Ready(ready1),
    .data_out(dout1), .data_out_we(dwe1),
    .data_in(din), .data_in_en(din_en),
    .irq(irq1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One bus access on the shared bus, then a fixed 12-cycle observation
  // window long enough for both devices to finish. restrobe>0 re-issues the
  // same strobe at that cycle after the original one.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input int restrobe);
    lat0 = -1; lat1 = -1; nrdy0 = 0; nrdy1 = 0; wec0 = 0; wec1 = 0;
    rd0 = '0; rd1 = '0; we0 = '0; we1 = '0;
    @(negedge Clk);
    addr = a; be = b; wdata = d;
    strb = 1'b1; wrs = wr; rds = !wr;
    for (int n = 1; n <= 12; n++) begin
      @(negedge Clk);
      strb = (n == restrobe);
      wrs  = strb & wr;
      rds  = strb & !wr;
      if (ready0) begin
        nrdy0++;
        if (lat0 < 0) begin lat0 = n; rd0 = rdata0; we0 = dwe0; end
      end
      if (ready1) begin
        nrdy1++;
        if (lat1 < 0) begin lat1 = n; rd1 = rdata1; we1 = dwe1; end
      end
      if (dwe0 != 8'h00) wec0++;
      if (dwe1 != 8'h00) wec1++;
    end
  endtask

  initial begin
    Reset = 1'b1; strb = 1'b0; rds = 1'b0; wrs = 1'b0;
    addr = '0; wdata = '0; be = '0; din = '0; din_en = '0;

    //           wr    addr           be       wdata          hit   exp_rd         exp_out                    exp_we        irq
    vecs[0]  = '{1'b1, 32'hC000_0000, 4'b0101, 32'hDEAD_BEEF, 1'b1, 32'h0,         64'h0000_0000_00AD_00EF, 8'b0000_0101, 1'b0};
    vecs[1]  = '{1'b1, 32'hC000_0004, 4'b1110, 32'hCAFE_F00D, 1'b1, 32'h0,         64'hCAFE_F000_00AD_00EF, 8'b1110_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hC000_0000, 4'b1010, 32'h1122_3344, 1'b1, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0000_1010, 1'b0};
    vecs[3]  = '{1'b0, 32'hC000_0000, 4'b1111, 32'h0,         1'b1, 32'h11AD_33EF, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[4]  = '{1'b0, 32'hC000_0006, 4'b1111, 32'h0,         1'b1, 32'hCAFE_F000, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[5]  = '{1'b0, 32'hC000_0008, 4'b1111, 32'h0,         1'b1, 32'h1234_5678, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[6]  = '{1'b0, 32'hC000_000C, 4'b1111, 32'h0,         1'b1, 32'h00BB_00DD, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[7]  = '{1'b0, 32'hC000_0010, 4'b1111, 32'h0,         1'b1, 32'h0000_0003, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[8]  = '{1'b1, 32'hC000_000C, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[9]  = '{1'b0, 32'hC000_000C, 4'b1111, 32'h0,         1'b1, 32'h00BB_00DD, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[10] = '{1'b1, 32'hC000_0018, 4'b1111, 32'h5555_5555, 1'b0, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[11] = '{1'b1, 32'hBFFF_FFFC, 4'b1111, 32'h5555_5555, 1'b0, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[12] = '{1'b0, 32'hC000_0018, 4'b1111, 32'h0,         1'b0, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[13] = '{1'b1, 32'hC000_0010, 4'b0000, 32'h0000_0002, 1'b1, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[14] = '{1'b0, 32'hC000_0010, 4'b1111, 32'h0,         1'b1, 32'h0000_0001, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[15] = '{1'b0, 32'hC000_0014, 4'b1111, 32'h0,         1'b1, 32'h0000_0000, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[16] = '{1'b1, 32'hC000_0014, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b1};
    vecs[17] = '{1'b0, 32'hC000_0014, 4'b1111, 32'h0,         1'b1, 32'h0000_0003, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b1};
    vecs[18] = '{1'b1, 32'hC000_0010, 4'b1111, 32'h0000_0001, 1'b1, 32'h0,         64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};
    vecs[19] = '{1'b0, 32'hC000_0010, 4'b1111, 32'h0,         1'b1, 32'h0000_0000, 64'hCAFE_F000_11AD_33EF, 8'b0,         1'b0};

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst dout0",  dout0,  64'h0);
    check("rst dout1",  dout1,  64'h0);
    check("rst dwe0",   dwe0,   8'h0);
    check("rst dwe1",   dwe1,   8'h0);
    check("rst ready0", ready0, 1'b0);
    check("rst ready1", ready1, 1'b0);
    check("rst rdata0", rdata0, 32'h0);
    check("rst rdata1", rdata1, 32'h0);
    check("rst irq0",   irq0,   1'b0);
    check("rst irq1",   irq1,   1'b0);
    Reset = 1'b0;

    // Capture IN0 fully and lanes 0/2 of IN1
    @(negedge Clk);
    din    = {32'hAABB_CCDD, 32'h1234_5678};
    din_en = 8'b0101_1111;
    @(negedge Clk);
    din_en = 8'h00;

    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, 0);
      check($sformatf("v%0d lat0", i), lat0, vecs[i].hit ? 1 : -1);
      check($sformatf("v%0d lat1", i), lat1, vecs[i].hit ? 4 : -1);
      if (!vecs[i].wr && vecs[i].hit) begin
        check($sformatf("v%0d rd0", i), rd0, vecs[i].exp_rd);
        check($sformatf("v%0d rd1", i), rd1, vecs[i].exp_rd);
      end
      check($sformatf("v%0d dout0", i), dout0, vecs[i].exp_out);
      check($sformatf("v%0d dout1", i), dout1, vecs[i].exp_out);
      check($sformatf("v%0d we0", i),   we0,   vecs[i].exp_we);
      check($sformatf("v%0d we1", i),   we1,   vecs[i].exp_we);
      check($sformatf("v%0d wecnt0", i), wec0, (vecs[i].exp_we != 8'h00) ? 1 : 0);
      check($sformatf("v%0d wecnt1", i), wec1, (vecs[i].exp_we != 8'h00) ? 1 : 0);
      check($sformatf("v%0d irq0", i), irq0, vecs[i].exp_irq);
      check($sformatf("v%0d irq1", i), irq1, vecs[i].exp_irq);
    end

    // irq follows a STATUS set by one cycle (IRQ_EN=3, STATUS=0 here)
    @(negedge Clk);
    din_en = 8'h01;
    @(negedge Clk);
    din_en = 8'h00;
    check("irq0 lag", irq0, 1'b0);
    check("irq1 lag", irq1, 1'b0);
    @(negedge Clk);
    check("irq0 set", irq0, 1'b1);
    check("irq1 set", irq1, 1'b1);

    // W1C on STATUS[0] with a capture on the strobe edge: dut0 commits on that
    // edge (set wins), dut1 commits three cycles later (bit clears).
    fork
      xfer(1'b1, 32'hC000_0010, 4'b1111, 32'h0000_0001, 0);
      begin
        @(negedge Clk);
        din_en = 8'h01;
        @(negedge Clk);
        din_en = 8'h00;
      end
    join
    xfer(1'b0, 32'hC000_0010, 4'b1111, 32'h0, 0);
    check("w1c race rd0", rd0, 32'h1);
    check("w1c plain rd1", rd1, 32'h0);
    check("w1c race irq0", irq0, 1'b1);
    check("w1c plain irq1", irq1, 1'b0);

    // Strobe repeated two cycles later: dut1 is in WAIT and must ignore it
    xfer(1'b0, 32'hC000_0000, 4'b1111, 32'h0, 2);
    check("ws3 lat1", lat1, 4);
    check("ws3 nrdy1", nrdy1, 1);
    check("ws3 rd1", rd1, 32'h11AD_33EF);
    check("ws0 nrdy0", nrdy0, 2);
    check("ws0 rd0", rd0, 32'h11AD_33EF);

    // Reset while dut1 is in WAIT
    fork
      xfer(1'b1, 32'hC000_0000, 4'b1111, 32'hA5A5_A5A5, 0);
      begin
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("mid rst dout0",  dout0,  64'h0);
        check("mid rst dout1",  dout1,  64'h0);
        check("mid rst rdata0", rdata0, 32'h0);
        check("mid rst rdata1", rdata1, 32'h0);
        check("mid rst ready1", ready1, 1'b0);
        check("mid rst irq0",   irq0,   1'b0);
        @(negedge Clk);
        Reset = 1'b0;
      end
    join
    check("abandon lat1",  lat1,  -1);
    check("abandon nrdy1", nrdy1, 0);
    check("abandon dout1", dout1, 64'h0);

    // Normal operation after reset
    xfer(1'b1, 32'hC000_0004, 4'b1111, 32'h0F0F_0F0F, 0);
    check("post lat0",  lat0,  1);
    check("post lat1",  lat1,  4);
    check("post dout0", dout0, 64'h0F0F_0F0F_0000_0000);
    check("post dout1", dout1, 64'h0F0F_0F0F_0000_0000);
    xfer(1'b0, 32'hC000_0004, 4'b1111, 32'h0, 0);
    check("post rd0", rd0, 32'h0F0F_0F0F);
    check("post rd1", rd1, 32'h0F0F_0F0F);
    xfer(1'b0, 32'hC000_0008, 4'b1111, 32'h0, 0);
    check("post in0 rd0", rd0, 32'h0);
    check("post in0 rd1", rd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
